// File: rtl/rx_inject_fsm.sv
// Ingress ring node: buffers port frames and injects them tagged {dest, word} into free ring slots.
// Head-to-ring latency 1 cycle; s_ready drops only when the FIFO is full; keep_in freezes all ring-side state.
module rx_inject_fsm #(
  parameter int NUB          = 0,
  parameter int PORT_NUB     = 8,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 11,
  parameter int FIFO_DEPTH   = 4,
  parameter int DONE_TIMEOUT = 1023,
  localparam int SEL_W       = $clog2(PORT_NUB),
  localparam int RING_W      = SEL_W + DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [RING_W-1:0]   ring_in_data,
  input  logic [SEL_W-1:0]    ring_in_nub,
  input  logic                ring_in_valid,
  input  logic                keep_in,
  input  logic [PORT_NUB-1:0] done_in,
  output logic [RING_W-1:0]   ring_out_data,
  output logic [SEL_W-1:0]    ring_out_nub,
  output logic                ring_out_valid,
  output logic                busy,
  output logic                err_drop,
  output logic                err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam int MK = DATA_W - SEL_W - 1;

  typedef enum logic [2:0] {
    IDLE      = 3'b001,
    SEND      = 3'b010,
    WAIT_DONE = 3'b100
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]  dest_q, dest_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [TW-1:0]     tmr_q, tmr_d, tmr_inc;
  logic [RING_W-1:0] out_dat_q, out_dat_d;
  logic [SEL_W-1:0]  out_nub_q, out_nub_d;
  logic              out_vld_q, out_vld_d;
  logic              err_drop_q, err_drop_d;
  logic              err_to_q, err_to_d;

  logic              push, pop, fifo_ne, inject;
  logic [SEL_W-1:0]  inj_dest;
  logic [DATA_W-1:0] head;
  logic              head_mark;
  logic [SEL_W-1:0]  head_dest;
  logic [LEN_W-1:0]  head_len;

  assign head      = mem_q[rd_ptr_q];
  assign head_mark = head[MK];
  assign head_dest = head[DATA_W-1 -: SEL_W];
  assign head_len  = head[LEN_W-1:0];
  assign fifo_ne   = (cnt_q != '0);
  assign s_ready   = (cnt_q != CW'(FIFO_DEPTH));
  assign push      = s_valid & s_ready;

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    tmr_d      = tmr_q;
    tmr_inc    = tmr_q + TW'(1);
    inject     = 1'b0;
    inj_dest   = dest_q;
    pop        = 1'b0;
    err_drop_d = 1'b0;
    err_to_d   = 1'b0;
    out_dat_d  = out_dat_q;
    out_nub_d  = out_nub_q;
    out_vld_d  = out_vld_q;

    if (!keep_in) begin
      unique case (state_q)
        IDLE: begin
          if (fifo_ne) begin
            // A stray payload word is discarded even while the slot is occupied.
            if (!head_mark) begin
              pop        = 1'b1;
              err_drop_d = 1'b1;
            end else if (!ring_in_valid) begin
              inject   = 1'b1;
              inj_dest = head_dest;
              pop      = 1'b1;
              dest_d   = head_dest;
              len_d    = head_len;
              state_d  = (head_len == '0) ? WAIT_DONE : SEND;
            end
          end
        end
        SEND: begin
          if (fifo_ne && !ring_in_valid) begin
            inject = 1'b1;
            pop    = 1'b1;
            len_d  = len_q - LEN_W'(1);
            if (len_q == LEN_W'(1)) state_d = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_in[dest_q]) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else if (tmr_inc == TW'(DONE_TIMEOUT)) begin
            state_d  = IDLE;
            tmr_d    = '0;
            err_to_d = 1'b1;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        default: state_d = IDLE;
      endcase

      if (ring_in_valid) begin
        out_dat_d = ring_in_data;
        out_nub_d = ring_in_nub;
        out_vld_d = 1'b1;
      end else if (inject) begin
        out_dat_d = {inj_dest, head};
        out_nub_d = SEL_W'(NUB);
        out_vld_d = 1'b1;
      end else begin
        out_dat_d = '0;
        out_nub_d = '0;
        out_vld_d = 1'b0;
      end
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      dest_q     <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
      out_dat_q  <= '0;
      out_nub_q  <= '0;
      out_vld_q  <= 1'b0;
      err_drop_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      tmr_q      <= tmr_d;
      out_dat_q  <= out_dat_d;
      out_nub_q  <= out_nub_d;
      out_vld_q  <= out_vld_d;
      err_drop_q <= err_drop_d;
      err_to_q   <= err_to_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  assign ring_out_data  = out_dat_q;
  assign ring_out_nub   = out_nub_q;
  assign ring_out_valid = out_vld_q;
  assign busy           = (state_q != IDLE);
  assign err_drop       = err_drop_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_rx_inject_fsm.sv
// Bench for rx_inject_fsm: directed vector tables, corner sequences, and random traffic against a frame-level model.
module tb_rx_inject_fsm;

  localparam int NUB   = 2;
  localparam int TO    = 15;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [34:0] ring_in_data;
  logic [2:0]  ring_in_nub;
  logic        ring_in_valid;
  logic        keep_in;
  logic [7:0]  done_in;
  logic [34:0] ring_out_data;
  logic [2:0]  ring_out_nub;
  logic        ring_out_valid;
  logic        busy;
  logic        err_drop;
  logic        err_timeout;

  rx_inject_fsm #(.NUB(NUB), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ring_in_data(ring_in_data), .ring_in_nub(ring_in_nub), .ring_in_valid(ring_in_valid),
    .keep_in(keep_in), .done_in(done_in),
    .ring_out_data(ring_out_data), .ring_out_nub(ring_out_nub), .ring_out_valid(ring_out_valid),
    .busy(busy), .err_drop(err_drop), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrl(input int dest, input int len);
    logic [31:0] w;
    w        = '0;
    w[31:29] = 3'(dest);
    w[28]    = 1'b1;
    w[10:0]  = 11'(len);
    return w;
  endfunction

  // Frame-level model: rem = -1 looking for a header, >0 payload words still owed, 0 awaiting completion.
  logic [31:0] mq[$];
  int          rem;
  int          mwait;
  logic [2:0]  mdest;
  logic        m_vld, m_drop, m_to;
  logic [2:0]  m_nub;
  logic [34:0] m_dat;

  task automatic model_reset();
    mq.delete();
    rem = -1; mwait = 0; mdest = '0;
    m_vld = 0; m_nub = '0; m_dat = '0; m_drop = 0; m_to = 0;
  endtask

  task automatic model_step(input logic sv, input logic [31:0] sd, input logic riv,
                            input logic [34:0] rid, input logic [2:0] rin,
                            input logic kp, input logic [7:0] dn);
    int          pre;
    logic        have, can;
    logic [31:0] h;
    pre  = mq.size();
    have = (pre > 0);
    h    = have ? mq[0] : 32'h0;
    m_drop = 0;
    m_to   = 0;
    if (!kp) begin
      can = have && (rem > 0 || (rem < 0 && h[28]));
      if (riv) begin
        m_vld = 1; m_nub = rin; m_dat = rid;
      end else if (can) begin
        m_vld = 1; m_nub = 3'(NUB); m_dat = {((rem < 0) ? h[31:29] : mdest), h};
      end else begin
        m_vld = 0; m_nub = '0; m_dat = '0;
      end
      if (rem < 0) begin
        if (have && !h[28]) begin
          mq.delete(0);
          m_drop = 1;
        end else if (can && !riv) begin
          mdest = h[31:29];
          rem   = int'(h[10:0]);
          mq.delete(0);
        end
      end else if (rem > 0) begin
        if (can && !riv) begin
          mq.delete(0);
          rem--;
        end
      end else begin
        mwait++;
        if (dn[mdest]) begin
          rem = -1; mwait = 0;
        end else if (mwait == TO) begin
          rem = -1; mwait = 0; m_to = 1;
        end
      end
    end
    if (sv && pre < DEPTH) mq.push_back(sd);
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({ring_out_valid, ring_out_nub, ring_out_data, busy, err_drop, err_timeout, s_ready});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({m_vld, m_nub, m_dat, (rem != -1), m_drop, m_to, (mq.size() < DEPTH)});
  endfunction

  task automatic tick(input logic sv, input logic [31:0] sd, input logic riv,
                      input logic [34:0] rid, input logic [2:0] rin,
                      input logic kp, input logic [7:0] dn);
    s_valid = sv; s_data = sd; ring_in_valid = riv; ring_in_data = rid;
    ring_in_nub = rin; keep_in = kp; done_in = dn;
    @(posedge clk);
    model_step(sv, sd, riv, rid, rin, kp, dn);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  // Source queue: a word leaves only once the DUT has accepted it.
  logic [31:0] src[$];

  task automatic cyc(input logic riv, input logic kp, input logic [7:0] dn, input logic want);
    logic        sv, acc;
    logic [31:0] sd;
    logic [34:0] rid;
    logic [2:0]  rin;
    sv  = want && (src.size() > 0);
    sd  = sv ? src[0] : $urandom;
    acc = sv && s_ready;
    rid = {3'($urandom_range(0, 7)), 32'($urandom)};
    rin = 3'(NUB + 1 + $urandom_range(0, 6));
    tick(sv, sd, riv, rid, rin, kp, dn);
    if (acc) src.delete(0);
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        kp;
    logic [7:0]  dn;
    logic        e_vld;
    logic [34:0] e_dat;
    logic        e_busy;
    logic        e_drop;
    logic        e_rdy;
  } vec_t;

  vec_t        tv[10];
  logic [34:0] got[$];
  logic [31:0] c1, c2, jw, p0, p1;
  logic [31:0] pw[6];
  int          k, cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 0; s_data = '0; ring_in_valid = 0; ring_in_data = '0;
    ring_in_nub = '0; keep_in = 0; done_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_vec(), 64'h1);
    rst_n = 1'b1;

    // Frame dest=3,len=2 then stray word and zero-length frame.
    c1 = ctrl(3, 2); p0 = 32'hA5A5_0001; p1 = 32'h5A5A_0002;
    jw = 32'hE000_1234; c2 = ctrl(5, 0);
    tv[0] = '{1'b1, c1, 1'b0, 8'h00, 1'b0, 35'h0,        1'b0, 1'b0, 1'b1};
    tv[1] = '{1'b1, p0, 1'b0, 8'hFF, 1'b1, {3'd3, c1},   1'b1, 1'b0, 1'b1};
    tv[2] = '{1'b1, p1, 1'b0, 8'hFF, 1'b1, {3'd3, p0},   1'b1, 1'b0, 1'b1};
    tv[3] = '{1'b0, '0, 1'b0, 8'h00, 1'b1, {3'd3, p1},   1'b1, 1'b0, 1'b1};
    tv[4] = '{1'b0, '0, 1'b0, 8'hF7, 1'b0, 35'h0,        1'b1, 1'b0, 1'b1};
    tv[5] = '{1'b0, '0, 1'b0, 8'h08, 1'b0, 35'h0,        1'b0, 1'b0, 1'b1};
    tv[6] = '{1'b1, jw, 1'b0, 8'h00, 1'b0, 35'h0,        1'b0, 1'b0, 1'b1};
    tv[7] = '{1'b1, c2, 1'b0, 8'h00, 1'b0, 35'h0,        1'b0, 1'b1, 1'b1};
    tv[8] = '{1'b0, '0, 1'b0, 8'h00, 1'b1, {3'd5, c2},   1'b1, 1'b0, 1'b1};
    tv[9] = '{1'b0, '0, 1'b0, 8'h20, 1'b0, 35'h0,        1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      tick(tv[i].sv, tv[i].sd, 1'b0, 35'h0, 3'h0, tv[i].kp, tv[i].dn);
      chk($sformatf("vec%0d_ring", i), 64'({ring_out_valid, ring_out_nub, ring_out_data}),
          64'({tv[i].e_vld, (tv[i].e_vld ? 3'(NUB) : 3'd0), tv[i].e_dat}));
      chk($sformatf("vec%0d_status", i), 64'({busy, err_drop, s_ready}),
          64'({tv[i].e_busy, tv[i].e_drop, tv[i].e_rdy}));
    end

    // Upstream traffic for 5 cycles mid-frame: order of injected words kept.
    for (int i = 0; i < 6; i++) pw[i] = 32'hC0DE_0000 + 32'(i);
    src.push_back(ctrl(1, 6));
    for (int i = 0; i < 6; i++) src.push_back(pw[i]);
    got.delete();
    for (int i = 0; i < 20; i++) begin
      cyc(i >= 3 && i < 8, 1'b0, 8'h00, 1'b1);
      if (ring_out_valid && ring_out_nub == 3'(NUB)) got.push_back(ring_out_data);
    end
    chk("pass_inj_count", 64'(got.size()), 64'd7);
    if (got.size() == 7) begin
      chk("pass_inj_ctrl", 64'(got[0]), 64'({3'd1, ctrl(1, 6)}));
      for (int i = 0; i < 6; i++) chk($sformatf("pass_inj_p%0d", i), 64'(got[i+1]), 64'({3'd1, pw[i]}));
    end
    cyc(1'b0, 1'b0, 8'h02, 1'b0);
    chk("pass_done_idle", 64'(busy), 64'd0);

    // Ring stall during SEND: output frozen, pushes continue until full.
    src.push_back(ctrl(6, 6));
    for (int i = 0; i < 6; i++) src.push_back(pw[i]);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b1);
      chk($sformatf("keep_frozen%0d", i), 64'({ring_out_valid, ring_out_data}), 64'({1'b1, 3'd6, pw[0]}));
    end
    chk("keep_full_rdy", 64'(s_ready), 64'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      if (ring_out_valid && ring_out_nub == 3'(NUB)) cnt++;
    end
    chk("keep_len_kept", 64'(cnt), 64'd5);
    cyc(1'b0, 1'b0, 8'h40, 1'b0);

    // Timeout with only foreign done bits, then a loopback frame follows.
    src.push_back(ctrl(4, 0));
    src.push_back(ctrl(NUB, 1));
    src.push_back(32'h1234_5678);
    k = 0;
    while (!busy && k < 10) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      k++;
    end
    chk("to_enter_wait", 64'(busy), 64'd1);
    k = 0;
    do begin
      cyc(1'b0, 1'b0, 8'hEF, 1'b1);
      k++;
    end while (!err_timeout && k < 60);
    chk("to_cycles", 64'(k), 64'(TO));
    chk("to_idle", 64'(busy), 64'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("to_next_frame", 64'({ring_out_valid, ring_out_nub, ring_out_data}),
        64'({1'b1, 3'(NUB), 3'(NUB), ctrl(NUB, 1)}));
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h04, 1'b0);

    // Asynchronous reset mid-SEND with two words buffered.
    src.push_back(ctrl(7, 5));
    for (int i = 0; i < 5; i++) src.push_back(pw[i]);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    s_valid = 0; ring_in_valid = 0; keep_in = 0; done_in = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out", 64'({ring_out_valid, ring_out_nub, ring_out_data, busy, err_drop, err_timeout}), 64'd0);
    chk("rst_async_rdy", 64'(s_ready), 64'd1);
    model_reset();
    src.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_flushed", 64'({ring_out_valid, busy, s_ready}), 64'({1'b0, 1'b0, 1'b1}));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] dn;
      if (src.size() < 4) begin
        if ($urandom_range(0, 99) < 85) begin
          int ln;
          ln = $urandom_range(0, 5);
          src.push_back(ctrl($urandom_range(0, 7), ln) | (32'($urandom) & 32'h0FFF_F800 & ~32'h1000_0000));
          for (int j = 0; j < ln; j++) src.push_back(32'($urandom) & 32'hFFFF_F807);
        end else begin
          src.push_back(32'($urandom) & 32'hEFFF_F807);
        end
      end
      r  = $urandom_range(0, 19);
      dn = (r == 0) ? 8'hFF : ((r < 4) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      cyc($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15, dn, $urandom_range(0, 99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
